// File: rtl/mux_arb_nto1.sv
// N-to-1 registered selector: direct-select or round-robin grant, valid/ready on every input and the output.
// Optional feature: define MUX_ARB_XFER_CNT_EN to add the xfer_cnt output-handshake counter port.
module mux_arb_nto1 #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_ARB_XFER_CNT_EN
  ,
  output logic [31:0]             xfer_cnt
`endif
);

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  int               rr_idx;

  assign mode_s = mode_e'(mode);

  // Grant decision. rst_n gates load_en so no channel is ever offered in_ready while in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    load_en   = rst_n && (!out_valid_q || out_ready);
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (load_en) begin
      if (mode_s == MODE_DIRECT) begin
        if ((int'(sel) < NUM_CH) && in_valid[sel]) begin
          grant_vld = 1'b1;
          grant_idx = sel;
        end
      end else begin
        for (int k = 1; k <= NUM_CH; k++) begin
          rr_idx = (int'(last_grant_q) + k) % NUM_CH;
          if (!grant_vld && in_valid[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(rr_idx);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld) in_ready[grant_idx] = 1'b1;
  end

  // A grant is only ever issued to a requesting channel, so grant_vld is the transfer strobe.
  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d   = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_ch_d     = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef MUX_ARB_XFER_CNT_EN
  logic [31:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: reset, direct select, round-robin fairness, backpressure, sparse RR + mode switch.
module tb_mux_arb_nto1;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MUX_ARB_XFER_CNT_EN
  logic [31:0]             xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mux_arb_nto1 #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_ARB_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] word_of(input int ch);
    return 32'hC0DE_0000 | WIDTH'(ch * 32'h0000_0101);
  endfunction

  task automatic load_words();
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = word_of(i);
  endtask

  // Inputs change 1 time unit after a rising edge; combinational checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 1'b1; sel = '0; out_ready = 1'b1; in_valid = 8'hFF;
    load_words();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++; if (out_ch !== 3'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got %h exp 00", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h01) begin errors++; $display("FAIL reset_first_grant got %h exp 01", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== word_of(0)) begin
      errors++; $display("FAIL reset_first_out got v=%0b ch=%0d d=%h exp v=1 ch=0 d=%h", out_valid, out_ch, out_data, word_of(0));
    end
    in_valid = 8'h00;
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_direct();
    mode = 1'b0; sel = 3'd5; out_ready = 1'b1; in_valid = 8'h20;
    in_data[5*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    checks++; if (in_ready !== 8'h20) begin errors++; $display("FAIL direct_in_ready got %h exp 20", in_ready); end
    next_cycle();
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL direct_out_data got %h exp deadbeef", out_data); end
    checks++; if (out_ch !== 3'd5) begin errors++; $display("FAIL direct_out_ch got %0d exp 5", out_ch); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_out_valid got %0b exp 1", out_valid); end
  endtask

  task automatic test_direct_noreq();
    sel = 3'd3; in_valid = 8'h10;
    #1;
    checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL noreq_in_ready got %h exp 00", in_ready); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noreq_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF || out_ch !== 3'd5) begin
      errors++; $display("FAIL noreq_hold got d=%h ch=%0d exp d=deadbeef ch=5", out_data, out_ch);
    end
    in_valid = 8'h00;
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    load_words();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      int exp_ch;
      exp_ch = k % NUM_CH;
      #1;
      checks++; if (in_ready !== 8'(1 << exp_ch)) begin
        errors++; $display("FAIL rr_in_ready[%0d] got %h exp %h", k, in_ready, 8'(1 << exp_ch));
      end
      next_cycle();
      checks++; if (out_valid !== 1'b1 || out_ch !== SEL_W'(exp_ch) || out_data !== word_of(exp_ch)) begin
        errors++; $display("FAIL rr_out[%0d] got v=%0b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                           k, out_valid, out_ch, out_data, exp_ch, word_of(exp_ch));
      end
    end
  endtask

  task automatic test_backpressure();
    // Continues from fairness: last grant was 1, all channels still requesting.
    next_cycle();
    checks++; if (out_ch !== 3'd2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_setup got ch=%0d v=%0b exp ch=2 v=1", out_ch, out_valid);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[2*WIDTH +: WIDTH] = 32'hBAD0_0002;
      #1;
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_in_ready[%0d] got %h exp 00", k, in_ready); end
      next_cycle();
      checks++; if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== word_of(2)) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b ch=%0d d=%h exp v=1 ch=2 d=%h",
                           k, out_valid, out_ch, out_data, word_of(2));
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL bp_release_ready got %h exp 08", in_ready); end
    next_cycle();
    checks++; if (out_ch !== 3'd3 || out_data !== word_of(3) || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_out got ch=%0d d=%h v=%0b exp ch=3 d=%h v=1", out_ch, out_data, out_valid, word_of(3));
    end
  endtask

  task automatic test_sparse_switch();
    logic [SEL_W-1:0] exp_seq [5];
    exp_seq = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd7};
    // Reset while out_valid is high: output must clear asynchronously.
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL midreset_clear got v=%0b d=%h exp v=0 d=00000000", out_valid, out_data);
    end
    next_cycle();
    rst_n = 1'b1;
    load_words();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h81;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        mode = 1'b0;
        sel  = 3'd7;
      end
      #1;
      checks++; if (in_ready !== 8'(1 << exp_seq[k])) begin
        errors++; $display("FAIL sparse_in_ready[%0d] got %h exp %h", k, in_ready, 8'(1 << exp_seq[k]));
      end
      next_cycle();
      checks++; if (out_ch !== exp_seq[k] || out_data !== word_of(int'(exp_seq[k])) || out_valid !== 1'b1) begin
        errors++; $display("FAIL sparse_out[%0d] got ch=%0d d=%h v=%0b exp ch=%0d", k, out_ch, out_data, out_valid, exp_seq[k]);
      end
    end
    in_valid = 8'h00;
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_drain got %0b exp 0", out_valid); end
`ifdef MUX_ARB_XFER_CNT_EN
    checks++; if (xfer_cnt !== 32'd5) begin errors++; $display("FAIL xfer_cnt got %0d exp 5", xfer_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    test_reset();
    test_direct();
    test_direct_noreq();
    test_rr_fairness();
    test_backpressure();
    test_sparse_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
